// File: rtl/timer_prog.sv
// Programmable interval timer: counts x*SCALE enabled ticks, pulses fin on expiry,
// one-shot or auto-reload, with pause (en), abort (stop) and restart (start).
module timer_prog #(
  parameter int N     = 4,
  parameter int SCALE = 10,
  parameter int CW    = N + 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          en,
  input  logic [N-1:0]  x,
  input  logic          periodic,
  output logic          busy,
  output logic          fin,
  output logic [CW-1:0] count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_limit;
  logic [CW-1:0] r_cnt;
  logic          r_mode;
  logic          r_fin;
  logic          r_busy;

  logic [CW-1:0] w_limit;
  logic          w_last;

  // Limit is formed at full counter width so the product never truncates.
  assign w_limit = CW'(x) * CW'(SCALE);
  assign w_last  = (r_cnt == r_limit - CW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_limit <= '0;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_fin   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      if (stop) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else if (start) begin
        r_cnt <= '0;
        if (x != '0) begin
          r_limit <= w_limit;
          r_mode  <= periodic;
          r_state <= RUN;
          r_busy  <= 1'b1;
        end else begin
          // Zero interval: immediate completion, never enters RUN.
          r_fin   <= 1'b1;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      end else if (r_state == RUN && en) begin
        if (w_last) begin
          r_cnt <= '0;
          r_fin <= 1'b1;
          if (!r_mode) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign busy  = r_busy;
  assign fin   = r_fin;
  assign count = r_cnt;

endmodule
